// File: rtl/ex_div.sv
// ex_div: multi-cycle 32-bit signed/unsigned radix-2 restoring divider for DIV/DIVU.
// The result appears 34 cycles after a request, or 2 cycles after one when the divisor is
// zero. It is held while start_i stays high.
//
// Ports:
//   Clk          - clock; all state changes on posedge
//   Rst_n        - synchronous active-low reset
//   signed_div_i - 1: DIV (two's complement), 0: DIVU
//   opdata1_i    - dividend, sampled on the accepting edge
//   opdata2_i    - divisor, sampled on the accepting edge
//   start_i      - level request; held high until ready_o is seen
//   annul_i      - cancels a requested or in-flight division
//   result_o     - {remainder, quotient}
//   ready_o      - result valid
module ex_div (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_abs, op2_abs;
  logic [32:0] diff;
  logic [31:0] quot_fix, rem_fix;

  // Signed operands are divided as magnitudes; signs are reapplied during fix-up.
  assign op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Trial subtraction of the divisor from the partial remainder; bit 32 set means borrow.
  assign diff = {1'b0, dvd_q[63:32]} - {1'b0, dvs_q};

  // Quotient truncates toward zero; the remainder takes the sign of the dividend.
  assign quot_fix = (neg1_q ^ neg2_q) ? (~dvd_q[31:0] + 32'd1) : dvd_q[31:0];
  assign rem_fix  = neg1_q ? (~dvd_q[64:33] + 32'd1) : dvd_q[64:33];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      StFree: begin
        ready_d  = 1'b0;
        result_d = 64'h0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'h0) begin
            state_d = StByZero;
          end else begin
            state_d = StOn;
            cnt_d   = 6'd0;
            dvd_d   = {32'h0, op1_abs, 1'b0};
            dvs_d   = op2_abs;
            neg1_d  = signed_div_i & opdata1_i[31];
            neg2_d  = signed_div_i & opdata2_i[31];
          end
        end
      end

      // Divide by zero yields all-zero result; annul_i deliberately has no effect here.
      StByZero: begin
        dvd_d    = 65'h0;
        state_d  = StEnd;
        result_d = 64'h0;
        ready_d  = 1'b1;
      end

      StOn: begin
        if (annul_i) begin
          state_d = StFree;
          cnt_d   = 6'd0;
          ready_d = 1'b0;
        end else if (cnt_q != 6'd32) begin
          if (diff[32]) begin
            dvd_d = {dvd_q[63:0], 1'b0};
          end else begin
            dvd_d = {diff[31:0], dvd_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          // Fix-up edge: apply signs and present the result on entry to StEnd.
          dvd_d    = {rem_fix, dvd_q[32], quot_fix};
          state_d  = StEnd;
          cnt_d    = 6'd0;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end
      end

      StEnd: begin
        if (!start_i) begin
          state_d  = StFree;
          ready_d  = 1'b0;
          result_d = 64'h0;
        end
      end

      default: begin
        state_d = StFree;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= StFree;
      cnt_q    <= 6'd0;
      dvd_q    <= 65'h0;
      dvs_q    <= 32'h0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= 64'h0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: an arithmetic reference model with a cycle countdown
// predicts ready_o/result_o every cycle, plus literal expectations for the directed cases.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = 32'h0;
  logic [31:0] op2 = 32'h0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_div dut (
    .Clk          (clk),
    .Rst_n        (rst_n),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  // Reference division from plain arithmetic: {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    if (b == 32'h0) return 64'h0;
    na = sgn & a[31];
    nb = sgn & b[31];
    ma = na ? (32'd0 - a) : a;
    mb = nb ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = 32'd0 - q;
    if (na) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Behavioural model: a request is busy for 33 edges (1 when dividing by zero), then the
  // result is shown until start drops.
  logic        m_ready = 1'b0;
  logic [63:0] m_result = 64'h0;
  logic        m_busy = 1'b0;
  logic        m_zero = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pending = 64'h0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready  = 1'b0;
      m_result = 64'h0;
      m_busy   = 1'b0;
    end else if (m_ready) begin
      if (!start) begin
        m_ready  = 1'b0;
        m_result = 64'h0;
      end
    end else if (m_busy) begin
      if (annul && !m_zero) begin
        m_busy = 1'b0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy   = 1'b0;
          m_ready  = 1'b1;
          m_result = m_pending;
        end
      end
    end else if (start && !annul) begin
      m_busy    = 1'b1;
      m_zero    = (op2 == 32'h0);
      m_left    = m_zero ? 1 : 33;
      m_pending = ref_div(op1, op2, signed_div);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ready_vs_model", {63'h0, ready}, {63'h0, m_ready});
    check("result_vs_model", result, m_result);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int hold, input logic lit_en, input logic [63:0] lit);
    int n;
    int exp_lat;
    op1        = a;
    op2        = b;
    signed_div = sgn;
    start      = 1'b1;
    exp_lat    = (b == 32'h0) ? 2 : 34;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 60);
    check("latency", 64'(n), 64'(exp_lat));
    if (lit_en) check("literal_result", result, lit);
    repeat (hold) tick();
    if (lit_en) check("held_result", result, lit);
    start = 1'b0;
    tick();
    check("ready_drop", {63'h0, ready}, 64'h0);
    check("result_drop", result, 64'h0);
  endtask

  task automatic run_annul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int k);
    op1        = a;
    op2        = b;
    signed_div = sgn;
    start      = 1'b1;
    repeat (k) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    start = 1'b0;
    check("annul_ready", {63'h0, ready}, 64'h0);
    repeat (36) begin
      tick();
      if (ready) check("annul_no_ready", {63'h0, ready}, 64'h0);
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) tick();
    check("reset_ready", {63'h0, ready}, 64'h0);
    check("reset_result", result, 64'h0);
    rst_n = 1'b1;
    tick();

    run_div(32'd100, 32'd7, 1'b0, 1, 1'b1, {32'd2, 32'd14});
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b1, {32'd1, 32'hFFFF_FFFD});
    run_div(32'h1234, 32'h0, 1'b0, 2, 1'b1, 64'h0);
    run_div(32'h1234, 32'h0, 1'b1, 0, 1'b1, 64'h0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b1, {32'h0, 32'hFFFF_FFFF});
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, {32'h0, 32'h8000_0000});

    // Annul partway through, then a fresh request must work normally.
    run_annul(32'd1000, 32'd3, 1'b0, 11);
    run_div(32'd9, 32'd3, 1'b0, 0, 1'b1, {32'h0, 32'd3});

    // Reset partway through.
    op1        = 32'd100;
    op2        = 32'd7;
    signed_div = 1'b0;
    start      = 1'b1;
    repeat (21) tick();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    check("midreset_ready", {63'h0, ready}, 64'h0);
    check("midreset_result", result, 64'h0);
    rst_n = 1'b1;
    tick();
    run_div(32'd100, 32'd7, 1'b0, 6, 1'b1, {32'd2, 32'd14});

    // Randomized traffic, with occasional annulled requests.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = rand_op();
      b = rand_op();
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0 && b != 32'h0) begin
        run_annul(a, b, s, $urandom_range(1, 33));
      end else begin
        run_div(a, b, s, $urandom_range(0, 6), 1'b1, ref_div(a, b, s));
      end
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit signed/unsigned divider serving DIV/DIVU in the execute stage. It is the stall *source* seen from the ID/EX register. EX starts it and holds its stall request while the divider is busy; the pipeline controller then freezes IF/ID/EX via `stall`. The divider uses radix-2 restoring division: 32 iteration cycles, plus fix-up and handshake cycles, a divide-by-zero shortcut, and an annul path for delay-slot/flush cancellation.

## Interface
- No parameters; widths are fixed by `RegBus` (32) and `DoubleRegBus` (64).
- `Clk` input 1: single clock; all state changes on posedge.
- `Rst_n` input 1: synchronous, active-low reset (`RstEnable` = 0), sampled on posedge `Clk`.
- `signed_div_i` input 1: 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` input 32: dividend; sampled only on the accepting edge.
- `opdata2_i` input 32: divisor; sampled only on the accepting edge.
- `start_i` input 1: level request from EX; must stay high until `ready_o` is seen.
- `annul_i` input 1: cancel the in-flight or requested division.
- `result_o` output 64: {remainder[63:32], quotient[31:0]}.
- `ready_o` output 1: result valid (`DivResultReady`).

## Operation
- States: FREE, BYZERO, ON, END. Internal state: 6-bit counter `cnt`, 65-bit work register `dvd`, latched divisor `dvs`, latched operand signs.
- Reset, every output and register: state FREE, `cnt`=0, `dvd`=0, `result_o`=0, `ready_o`=0.
- **FREE**
  - `start_i`=1 and `annul_i`=0, divisor==0: go to BYZERO.
  - `start_i`=1 and `annul_i`=0, divisor!=0: go to ON with `cnt`=0.
    - If `signed_div_i`=1, negative operands are replaced by their two's complement magnitude.
    - `dvd` <= {32'b0, |dividend|, 1'b0}; `dvs` <= |divisor|.
    - Original sign bits of both operands are latched.
  - Otherwise: `ready_o`=0, `result_o`=0.
- **BYZERO**: `dvd` <= 0; unconditionally go to END. `annul_i` is ignored here.
- **ON**
  - `annul_i`=1: go to FREE, `cnt`=0, `ready_o`=0. No result is produced.
  - `cnt`!=32: compute `diff` = {1'b0,`dvd`[63:32]} − {1'b0,`dvs`} (33-bit).
    - `diff`[32]=1: `dvd` <= {`dvd`[63:0],1'b0}.
    - Else: `dvd` <= {`diff`[31:0],`dvd`[31:0],1'b1}.
    - `cnt`++ in both cases.
  - `cnt`==32 (fix-up):
    - Signed and dividend sign ^ divisor sign: negate quotient `dvd`[31:0].
    - Signed and dividend negative: negate remainder `dvd`[64:33].
    - Go to END; `cnt`=0.
- **END**
  - On entry, `result_o` <= {`dvd`[64:33], `dvd`[31:0]} and `ready_o` <= 1.
  - Stay in END while `start_i`=1.
  - `start_i`=0: go to FREE, `ready_o`=0, `result_o`=0.
- Divide-by-zero result is 64'h0 (quotient 0, remainder 0). No exception is raised.
- Signed overflow (0x80000000 / −1) wraps: quotient 0x80000000, remainder 0.
- Remainder sign always follows the dividend; quotient truncates toward zero.

## Timing
- Edge numbering: edge 0 is the posedge where FREE samples `start_i`=1.
- Normal division: ON after edge 0; iterations on edges 1–32; fix-up on edge 33.
- `ready_o`=1 and `result_o` valid after edge 33, i.e. 34 cycles from request.
- Divide by zero: BYZERO after edge 0, END after edge 1; `ready_o`=1 two cycles after the request.
- `result_o`/`ready_o` hold stable in END for as long as `start_i` stays high.
- Deassert: `start_i` low at edge n gives `ready_o`=0 after edge n. A new request is accepted no earlier than edge n+1.
- `annul_i` in ON takes effect on the same edge. `annul_i` with `start_i` in FREE blocks acceptance.
- Reset asserted mid-operation in any state returns to FREE with all outputs 0 on that edge.
- EX contract: `stallreq_for_div` = `start_i` & ~`ready_o`. The pipeline therefore stalls stages 0–3 until `ready_o`, and ID/EX holds its contents rather than inserting a bubble.

## Test plan
- Unsigned: 100 / 7, signed_div=0 → after 34 cycles, `result_o` = {32'd2, 32'd14}, `ready_o`=1; drop `start_i` → next cycle `ready_o`=0, `result_o`=0.
- Signed: −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also 7 / −2 → quotient −3, remainder +1.
- Divide by zero: 0x1234 / 0, both signed and unsigned → `ready_o`=1 two cycles after request, `result_o`=0.
- Boundary: 0xFFFFFFFF / 1 unsigned → quotient 0xFFFFFFFF, remainder 0. 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0.
- Annul: start 1000 / 3, assert `annul_i` at iteration 10 → FREE next cycle, `ready_o` never rises. A new request 9 / 3 then returns {0, 3}.
- Reset mid-division (`Rst_n`=0 at iteration 20) → next cycle all outputs 0 and state FREE. Holding `start_i` high in END keeps the result stable for 5+ cycles.
